// File: rtl/ser_load_pkg.sv
// Shared types for the serial chain loader: FSM state encoding and counter sizing.
// ST_PARITY keeps its encoding even when SER_LOAD_PARITY_EN is not defined.
package ser_load_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SHIFT  = 2'b01,
    ST_PARITY = 2'b10,
    ST_LATCH  = 2'b11
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/ser_load_ctrl_if.sv
// Parallel-word handshake in, serial chain drive out.
// The master modport is the source and chain side; the slave modport is the sequencer.
interface ser_load_ctrl_if #(parameter int WIDTH = 8);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             ser_dout;
  logic             ser_shift_en;
  logic             latch_strobe;
  logic             busy;
  logic             done;

  modport master (
    output in_valid, in_data,
    input  in_ready, ser_dout, ser_shift_en, latch_strobe, busy, done
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, ser_dout, ser_shift_en, latch_strobe, busy, done
  );

endinterface

// File: rtl/ser_bit_counter.sv
// Clearable up-counter with an equality flag at a programmable terminal value.
// Clear has priority over increment.
module ser_bit_counter #(
  parameter int CW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          inc_i,
  input  logic [CW-1:0] term_val_i,
  output logic          term_o
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == term_val_i);

endmodule

// File: rtl/ser_load_ctrl.sv
// Serializes an accepted word into a D-flop chain, then pulses latch_strobe/done.
// SER_LOAD_PARITY_EN appends an even-parity bit as one extra shift cycle before the latch.
module ser_load_ctrl
  import ser_load_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic           clk,
  input  logic           reset,
  ser_load_ctrl_if.slave bus
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] TERM = CW'(WIDTH - 1);

  state_e           state_q;
  logic [WIDTH-1:0] shadow_q;
  logic [WIDTH-1:0] shadow_sh;
  logic             head_in;
  logic             head_sh;
  logic             dout_q;
  logic             shift_en_q;
  logic             latch_q;
  logic             busy_q;
  logic             ready_q;
  logic             cnt_clr;
  logic             cnt_inc;
  logic             cnt_term;
`ifdef SER_LOAD_PARITY_EN
  logic             par_q;
`endif

  // head_sh is the bit that reaches the chain on the next shift cycle.
  always_comb begin
    if (MSB_FIRST) begin
      shadow_sh = {shadow_q[WIDTH-2:0], 1'b0};
      head_in   = bus.in_data[WIDTH-1];
      head_sh   = shadow_q[WIDTH-2];
    end else begin
      shadow_sh = {1'b0, shadow_q[WIDTH-1:1]};
      head_in   = bus.in_data[0];
      head_sh   = shadow_q[1];
    end
  end

  assign cnt_clr = (state_q == ST_IDLE) && bus.in_valid;
  assign cnt_inc = (state_q == ST_SHIFT);

  ser_bit_counter #(.CW(CW)) u_cnt (
    .clk        (clk),
    .rst_n      (reset),
    .clr_i      (cnt_clr),
    .inc_i      (cnt_inc),
    .term_val_i (TERM),
    .term_o     (cnt_term)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      shadow_q   <= '0;
      dout_q     <= 1'b0;
      shift_en_q <= 1'b0;
      latch_q    <= 1'b0;
      busy_q     <= 1'b0;
      ready_q    <= 1'b1;
`ifdef SER_LOAD_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.in_valid) begin
            state_q    <= ST_SHIFT;
            shadow_q   <= bus.in_data;
            dout_q     <= head_in;
            shift_en_q <= 1'b1;
            busy_q     <= 1'b1;
            ready_q    <= 1'b0;
`ifdef SER_LOAD_PARITY_EN
            par_q      <= ^bus.in_data;
`endif
          end
        end
        ST_SHIFT: begin
          shadow_q <= shadow_sh;
          if (cnt_term) begin
`ifdef SER_LOAD_PARITY_EN
            state_q    <= ST_PARITY;
            dout_q     <= par_q;
`else
            state_q    <= ST_LATCH;
            dout_q     <= 1'b0;
            shift_en_q <= 1'b0;
            latch_q    <= 1'b1;
`endif
          end else begin
            dout_q <= head_sh;
          end
        end
`ifdef SER_LOAD_PARITY_EN
        ST_PARITY: begin
          state_q    <= ST_LATCH;
          dout_q     <= 1'b0;
          shift_en_q <= 1'b0;
          latch_q    <= 1'b1;
        end
`endif
        ST_LATCH: begin
          state_q <= ST_IDLE;
          latch_q <= 1'b0;
          busy_q  <= 1'b0;
          ready_q <= 1'b1;
        end
        default: begin
          state_q    <= ST_IDLE;
          dout_q     <= 1'b0;
          shift_en_q <= 1'b0;
          latch_q    <= 1'b0;
          busy_q     <= 1'b0;
          ready_q    <= 1'b1;
        end
      endcase
    end
  end

  assign bus.in_ready     = ready_q;
  assign bus.ser_dout     = dout_q;
  assign bus.ser_shift_en = shift_en_q;
  assign bus.latch_strobe = latch_q;
  assign bus.done         = latch_q;
  assign bus.busy         = busy_q;

endmodule

// File: tb/tb_ser_load_ctrl.sv
// Drives an MSB-first and an LSB-first instance with the same words and checks
// each against expected bit streams, chain reconstruction and latch timing.
module tb_ser_load_ctrl;

  localparam int W = 8;
`ifdef SER_LOAD_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int NB = W + PAR;

  logic clk;
  logic reset;
  int   errors;
  int   checks;
  int   words_done;
  int   lat_m;
  int   lat_l;
  time  t1;
  time  t2;
  logic [W-1:0] rw;
  bit   rh;
  bit   prev_hold;

  ser_load_ctrl_if #(.WIDTH(W)) bm ();
  ser_load_ctrl_if #(.WIDTH(W)) bl ();

  ser_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_m (.clk(clk), .reset(reset), .bus(bm));
  ser_load_ctrl #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_l (.clk(clk), .reset(reset), .bus(bl));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bm.latch_strobe === 1'b1) lat_m++;
    if (bl.latch_strobe === 1'b1) lat_l++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d);
    bm.in_valid = v;
    bl.in_valid = v;
    bm.in_data  = d;
    bl.in_data  = d;
  endtask

  // {in_ready, ser_shift_en, latch_strobe, busy, done, ser_dout}
  task automatic chk_idle(input string tag);
    chk({tag, "_m"}, 64'({bm.in_ready, bm.ser_shift_en, bm.latch_strobe, bm.busy, bm.done, bm.ser_dout}), 64'(6'b100000));
    chk({tag, "_l"}, 64'({bl.in_ready, bl.ser_shift_en, bl.latch_strobe, bl.busy, bl.done, bl.ser_dout}), 64'(6'b100000));
  endtask

  // Entered and left at a negedge. abort_at >= 0 pulls reset after that many shift cycles.
  task automatic send(input logic [W-1:0] w, input bit hold, input int abort_at, output time t_lat);
    logic [NB-1:0] cm;
    logic [NB-1:0] cl;
    int  n;
    bit  p;
    bit  em;
    bit  el;
    time t_acc;
    t_lat = 0;
    p = ($countones(w) % 2) == 1;
    n = 0;
    while (bm.in_ready !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    chk("ready_before_accept", 64'(bm.in_ready), 64'(1));
    drive(1'b1, w);
    @(posedge clk);
    t_acc = $time;
    @(negedge clk);
    cm = '0;
    cl = '0;
    for (int i = 0; i < NB; i++) begin
      if (i == abort_at) begin
        reset = 1'b0;
        drive(1'b0, '0);
        #1;
        chk_idle("abort_immediate");
        repeat (2) begin
          @(negedge clk);
          chk_idle("abort_hold");
        end
        reset = 1'b1;
        return;
      end
      em = (i < W) ? w[W-1-i] : p;
      el = (i < W) ? w[i] : p;
      // {ser_shift_en, busy, in_ready, latch_strobe, done, ser_dout}
      chk("shift_m", 64'({bm.ser_shift_en, bm.busy, bm.in_ready, bm.latch_strobe, bm.done, bm.ser_dout}),
          64'({5'b11000, em}));
      chk("shift_l", 64'({bl.ser_shift_en, bl.busy, bl.in_ready, bl.latch_strobe, bl.done, bl.ser_dout}),
          64'({5'b11000, el}));
      cm = {cm[NB-2:0], bm.ser_dout};
      cl = {bl.ser_dout, cl[NB-1:1]};
      drive(hold ? 1'b1 : 1'($urandom), W'($urandom));
      @(negedge clk);
    end
    chk("latch_m", 64'({bm.ser_shift_en, bm.busy, bm.in_ready, bm.latch_strobe, bm.done, bm.ser_dout}), 64'(6'b010110));
    chk("latch_l", 64'({bl.ser_shift_en, bl.busy, bl.in_ready, bl.latch_strobe, bl.done, bl.ser_dout}), 64'(6'b010110));
    chk("chain_m", 64'(cm[NB-1 -: W]), 64'(w));
    chk("chain_l", 64'(cl[W-1:0]), 64'(w));
    t_lat = $time;
    chk("latch_latency", 64'(t_lat - t_acc), 64'((W + PAR) * 10 + 5));
    words_done++;
    @(negedge clk);
    chk("ready_after_m", 64'({bm.in_ready, bm.ser_shift_en, bm.latch_strobe, bm.busy, bm.done}), 64'(5'b10000));
    chk("ready_after_l", 64'({bl.in_ready, bl.ser_shift_en, bl.latch_strobe, bl.busy, bl.done}), 64'(5'b10000));
    if (!hold) drive(1'b0, '0);
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    words_done = 0;
    lat_m      = 0;
    lat_l      = 0;
    prev_hold  = 1'b0;
    reset      = 1'b0;
    drive(1'b0, '0);
    repeat (3) @(negedge clk);
    chk_idle("in_reset");
    reset = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk_idle("idle_after_reset");
    end

    send(8'hA5, 1'b0, -1, t1);
    send(8'h01, 1'b0, -1, t1);
    send(8'h07, 1'b0, -1, t1);

    send(8'h3C, 1'b1, -1, t1);
    send(8'hC3, 1'b0, -1, t2);
    chk("b2b_latch_spacing", 64'(t2 - t1), 64'((W + 2 + PAR) * 10));

    send(8'hFF, 1'b0, 4, t1);
    send(8'h12, 1'b0, -1, t1);

    for (int r = 0; r < 24; r++) begin
      rw = W'($urandom);
      rh = (r < 23) ? 1'($urandom) : 1'b0;
      if (!prev_hold) repeat ($urandom_range(0, 3)) @(negedge clk);
      send(rw, rh, -1, t1);
      prev_hold = rh;
    end

    repeat (3) @(negedge clk);
    chk("latch_count_m", 64'(lat_m), 64'(words_done));
    chk("latch_count_l", 64'(lat_l), 64'(words_done));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
